// File: rtl/fifo_uart_reader.sv
// Purpose : drains the sample FIFO and sends each WIDTH-bit code as two 8N1 UART bytes, high byte first.
// Latency : RdEnable in the cycle IDLE sees a non-empty FIFO; start bit 2 cycles later; word period 20*BAUD_DIV+2.
// Backpr. : no pop while Empty=1 or Enable=0 (Enable only sampled in IDLE); a started word always completes.
//
// Ports:
//   clk        system clock
//   Reset      asynchronous active-low reset; all outputs go to idle values immediately
//   Enable     drain enable, looked at only while idle
//   Empty      FIFO empty flag
//   RdData     FIFO read data, valid the cycle after RdEnable
//   RdEnable   single-cycle FIFO pop strobe
//   TxD        UART line, idles high
//   Busy       high while a word is being fetched or shifted out
//   WordCount  words fully transmitted since reset, wraps modulo 2^16
//
// WIDTH must lie in 9..16 so the high byte holds 1..8 bits; BAUD_DIV must be at least 2.

module fifo_uart_reader #(
    parameter int WIDTH    = 10,
    parameter int BAUD_DIV = 868
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Empty,
    input  logic [WIDTH-1:0] RdData,
    output logic             RdEnable,
    output logic             TxD,
    output logic             Busy,
    output logic [15:0]      WordCount
);

    // Baud counter just wide enough to reach BAUD_DIV-1.
    localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    state_t           state_q,      state_d;
    logic [BCW-1:0]   baud_cnt_q,   baud_cnt_d;
    logic [2:0]       bit_idx_q,    bit_idx_d;
    logic             byte_idx_q,   byte_idx_d;
    logic [WIDTH-1:0] word_q,       word_d;
    logic [15:0]      word_count_q, word_count_d;

    logic             pop;
    logic             baud_done;
    logic [7:0]       hi_byte;
    logic [7:0]       cur_byte;
    logic             tx_bit;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= 1'b0;
            word_q       <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            word_count_q <= word_count_d;
        end
    end

    assign baud_done = (baud_cnt_q == BAUD_LAST);

    // ------------------------------------------------------------------
    // Next-state logic. The baud counter is cleared on every state entry
    // and at every data-bit boundary, so each line symbol lasts exactly
    // BAUD_DIV cycles regardless of which state produced it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        word_count_d = word_count_q;
        pop          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Enable && !Empty) begin
                    pop        = 1'b1;
                    state_d    = ST_FETCH;
                    baud_cnt_d = '0;
                end
            end

            // RdData is valid now, one cycle after the pop.
            ST_FETCH: begin
                word_d     = RdData;
                byte_idx_d = 1'b0;
                bit_idx_d  = '0;
                baud_cnt_d = '0;
                state_d    = ST_START;
            end

            ST_START: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + BCW'(1);
                end
            end

            ST_DATA: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BCW'(1);
                end
            end

            // After the high byte's stop bit the low byte's start bit
            // follows immediately; after the low byte the word is done.
            ST_STOP: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    if (!byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        state_d    = ST_START;
                    end else begin
                        byte_idx_d   = 1'b0;
                        word_count_d = word_count_q + 16'd1;
                        state_d      = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BCW'(1);
                end
            end

            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Line encoding. Decoded from registers only, so TxD changes only
    // right after a clock edge (or immediately on reset).
    // ------------------------------------------------------------------
    always_comb begin
        hi_byte                = '0;
        hi_byte[WIDTH-9:0]     = word_q[WIDTH-1:8];
        cur_byte               = byte_idx_q ? word_q[7:0] : hi_byte;
        case (state_q)
            ST_START: tx_bit = 1'b0;
            ST_DATA:  tx_bit = cur_byte[bit_idx_q];
            default:  tx_bit = 1'b1;
        endcase
    end

    // The state register is already forced to IDLE by the asynchronous
    // reset; RdEnable is additionally gated by Reset because in IDLE it is
    // a function of the live Enable/Empty inputs and would otherwise pulse
    // while the block is held in reset.
    assign RdEnable  = pop & Reset;
    assign TxD       = tx_bit;
    assign Busy      = (state_q != ST_IDLE);
    assign WordCount = word_count_q;

endmodule

// File: tb/tb_fifo_uart_reader.sv
module tb_fifo_uart_reader;

    localparam int WIDTH = 10;
    localparam int BD    = 4;
    localparam int WORD_PERIOD = 20 * BD + 2;

    logic             clk = 1'b0;
    logic             Reset;
    logic             Enable;
    logic             Empty;
    logic [WIDTH-1:0] RdData = '0;
    logic             RdEnable;
    logic             TxD;
    logic             Busy;
    logic [15:0]      WordCount;

    always #5 clk = ~clk;

    fifo_uart_reader #(
        .WIDTH    (WIDTH),
        .BAUD_DIV (BD)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Enable    (Enable),
        .Empty     (Empty),
        .RdData    (RdData),
        .RdEnable  (RdEnable),
        .TxD       (TxD),
        .Busy      (Busy),
        .WordCount (WordCount)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // ------------------------------------------------------------------
    // FIFO model: data appears on RdData the cycle after a pop.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] fifo_mem [0:63];
    int  wr_ptr  = 0;
    int  rd_ptr  = 0;
    int  pop_cnt = 0;
    int  pop_cyc [$];
    bit  rd_req  = 1'b0;

    assign Empty = (wr_ptr == rd_ptr);

    always @(negedge clk) begin
        rd_req = 1'b0;
        if (RdEnable === 1'b1) begin
            chk("pop_while_empty", 32'(Empty), 32'd0);
            pop_cnt++;
            pop_cyc.push_back(cyc);
            if (!Empty) rd_req = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rd_req) begin
            RdData <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard of expected UART bytes, filled when words are queued.
    // ------------------------------------------------------------------
    logic [7:0] exp_q [$];
    int         start_q [$];

    task automatic push_word(input logic [WIDTH-1:0] w);
        logic [7:0] hi;
        hi = '0;
        hi[WIDTH-9:0] = w[WIDTH-1:8];
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(hi);
        exp_q.push_back(w[7:0]);
    endtask

    // ------------------------------------------------------------------
    // UART receiver: samples each symbol in its middle, relative to the
    // first cycle in which the start bit is seen.
    // ------------------------------------------------------------------
    bit         mon_busy = 1'b0;
    int         mon_t0   = 0;
    logic [7:0] mon_byte = '0;

    always @(negedge clk) begin : uart_mon
        int rel;
        int k;
        if (Reset !== 1'b1) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (TxD === 1'b0) begin
                mon_busy = 1'b1;
                mon_t0   = cyc;
                start_q.push_back(cyc);
            end
        end else begin
            rel = cyc - mon_t0;
            if (rel % BD == BD / 2) begin
                k = rel / BD;
                if (k == 0) begin
                    chk("start_bit", 32'(TxD), 32'd0);
                end else if (k <= 8) begin
                    mon_byte[k-1] = TxD;
                end else begin
                    chk("stop_bit", 32'(TxD), 32'd1);
                    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) chk("uart_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                    mon_busy = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pops(input int n, input int limit, input string tag);
        int t;
        t = 0;
        while (pop_cnt < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(pop_cnt >= n), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        Reset = 1'b0;
        wait_cyc(2);
        Reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int base;
        int pc;

        // Reset and idle with an empty FIFO.
        Reset  = 1'b0;
        Enable = 1'b1;
        wait_cyc(3);
        chk("rst_txd",   32'(TxD),       32'd1);
        chk("rst_rden",  32'(RdEnable),  32'd0);
        chk("rst_busy",  32'(Busy),      32'd0);
        chk("rst_wc",    32'(WordCount), 32'd0);
        Reset = 1'b1;
        wait_cyc(20);
        chk("idle_txd",  32'(TxD),       32'd1);
        chk("idle_busy", 32'(Busy),      32'd0);
        chk("idle_wc",   32'(WordCount), 32'd0);
        chk("idle_pops", 32'(pop_cnt),   32'd0);

        // Single word 0x2A5 -> bytes 02, A5.
        start_q.delete();
        push_word(10'h2A5);
        wait_pops(1, 20, "single_pop");
        pc = pop_cyc[0];
        while (cyc < pc + WORD_PERIOD - 1) @(negedge clk);
        chk("single_busy_last", 32'(Busy),      32'd1);
        chk("single_wc_last",   32'(WordCount), 32'd0);
        @(negedge clk);
        chk("single_wc",        32'(WordCount), 32'd1);
        chk("single_busy_done", 32'(Busy),      32'd0);
        chk("single_starts",    32'(start_q.size()), 32'd2);
        if (start_q.size() >= 2) begin
            chk("start_latency", 32'(start_q[0] - pc),         32'd2);
            chk("byte_gap",      32'(start_q[1] - start_q[0]), 32'(10 * BD));
        end
        chk("single_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("single_pops",     32'(pop_cnt),      32'd1);

        // Back-to-back drain of three words.
        pulse_reset();
        base = pop_cnt;
        push_word(10'h000);
        push_word(10'h3FF);
        push_word(10'h155);
        wait_pops(base + 3, 400, "drain_pops_seen");
        wait_cyc(WORD_PERIOD + 100);
        chk("drain_pop_total", 32'(pop_cnt - base), 32'd3);
        if (pop_cyc.size() >= base + 3) begin
            chk("drain_space_1", 32'(pop_cyc[base+1] - pop_cyc[base]),   32'(WORD_PERIOD));
            chk("drain_space_2", 32'(pop_cyc[base+2] - pop_cyc[base+1]), 32'(WORD_PERIOD));
        end
        chk("drain_wc",       32'(WordCount),    32'd3);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        // Enable dropped during byte 0 of the first of two queued words.
        base = pop_cnt;
        push_word(10'h1C3);
        push_word(10'h07E);
        wait_pops(base + 1, 20, "en_first_pop");
        wait_cyc(10);
        Enable = 1'b0;
        wait_cyc(WORD_PERIOD + 80);
        chk("en_off_pops",    32'(pop_cnt - base), 32'd1);
        chk("en_off_wc",      32'(WordCount),      32'd4);
        chk("en_off_busy",    32'(Busy),           32'd0);
        chk("en_off_pending", 32'(exp_q.size()),   32'd2);
        Enable = 1'b1;
        wait_pops(base + 2, 20, "en_resume_pop");
        wait_cyc(WORD_PERIOD + 10);
        chk("en_on_wc",       32'(WordCount),    32'd5);
        chk("en_sb_empty",    32'(exp_q.size()), 32'd0);

        // Reset during DATA bit 3 of the high byte (0x02, bit 3 = 0).
        base = pop_cnt;
        push_word(10'h2F0);
        push_word(10'h10F);
        wait_pops(base + 1, 20, "mid_first_pop");
        pc = pop_cyc[base];
        while (cyc < pc + 2 + BD + 3 * BD + 1) @(negedge clk);
        chk("mid_pre_txd", 32'(TxD), 32'd0);
        #1 Reset = 1'b0;
        #1;
        chk("mid_rst_txd",  32'(TxD),       32'd1);
        chk("mid_rst_rden", 32'(RdEnable),  32'd0);
        chk("mid_rst_busy", 32'(Busy),      32'd0);
        chk("mid_rst_wc",   32'(WordCount), 32'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        wait_cyc(3);
        Reset = 1'b1;
        wait_pops(base + 2, 20, "mid_next_pop");
        wait_cyc(WORD_PERIOD + 10);
        chk("mid_after_wc",   32'(WordCount),    32'd1);
        chk("mid_after_busy", 32'(Busy),         32'd0);
        chk("mid_sb_empty",   32'(exp_q.size()), 32'd0);

        // WordCount wrap from 65535.
        force dut.word_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.word_count_q;
        @(negedge clk);
        chk("wrap_pre", 32'(WordCount), 32'h0000FFFF);
        base = pop_cnt;
        push_word(10'h0AA);
        wait_pops(base + 1, 20, "wrap_pop");
        wait_cyc(WORD_PERIOD + 10);
        chk("wrap_wc",       32'(WordCount),    32'd0);
        chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
